// File: rtl/octal_reg_seq_pkg.sv
// Shared types and constants for the octal register write sequencer.
package octal_reg_seq_pkg;

  // Write sequence phases: grant, data setup, clock strobe, data hold.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // One-hot grant encoding, bit 0 = requester A, bit 1 = requester B.
  localparam logic [1:0] GNT_A = 2'b01;
  localparam logic [1:0] GNT_B = 2'b10;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter. Grants only while enabled; on a tie the
// requester that was not granted last wins. After reset A has priority.
module rr_arbiter2
  import octal_reg_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_gnt
);

  // High when B was granted most recently, which hands the next tie to A.
  logic       r_last_b;
  logic [1:0] w_gnt;

  // Combinational grant selection from the current requests.
  always_comb begin
    w_gnt = 2'b00;
    if (i_en) begin
      case (i_req)
        2'b01:   w_gnt = GNT_A;
        2'b10:   w_gnt = GNT_B;
        2'b11:   w_gnt = r_last_b ? GNT_A : GNT_B;
        default: w_gnt = 2'b00;
      endcase
    end
  end

  // Remember who won the last grant; reset leaves A with priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_b <= 1'b1;
    end else if (|w_gnt) begin
      r_last_b <= (w_gnt == GNT_B);
    end
  end

  assign o_gnt = w_gnt;

endmodule

// File: rtl/octal_reg_write_sequencer.sv
// Shares a bank of edge-triggered octal registers between two requesters.
// Each write runs SETUP (data on bus), STROBE (one register clock high) and
// HOLD (data still stable, ack) so the register clock edge always sees a
// settled data bus. reg_clk, acks and err come straight from flops.
module octal_reg_write_sequencer
  import octal_reg_seq_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int WIDTH    = 8,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_a,
  input  logic [ADDR_W-1:0]   addr_a,
  input  logic [WIDTH-1:0]    data_a,
  output logic                ack_a,
  input  logic                req_b,
  input  logic [ADDR_W-1:0]   addr_b,
  input  logic [WIDTH-1:0]    data_b,
  output logic                ack_b,
  output logic [WIDTH-1:0]    reg_d,
  output logic [NUM_REGS-1:0] reg_clk,
  output logic                busy,
  output logic                err
);

  localparam logic [ADDR_W:0] LP_NUM_REGS = (ADDR_W + 1)'(NUM_REGS);

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [WIDTH-1:0]    r_data;
  logic                r_gnt_b;
  logic [NUM_REGS-1:0] r_reg_clk;
  logic [NUM_REGS-1:0] w_reg_clk_next;
  logic [NUM_REGS-1:0] w_dec;
  logic                r_ack_a;
  logic                r_ack_b;
  logic                r_err;
  logic                w_ack_a_next;
  logic                w_ack_b_next;
  logic                w_err_next;
  logic                w_latch;
  logic                w_addr_bad;
  logic [1:0]          w_gnt;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .i_req ({req_b, req_a}),
    .i_en  (r_state == IDLE),
    .o_gnt (w_gnt)
  );

  // Latched address that has no register behind it is rejected, not strobed.
  assign w_addr_bad = ({1'b0, r_addr} >= LP_NUM_REGS);

  // One strobe line per register, selected by the latched address.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dec
    assign w_dec[gi] = (r_addr == ADDR_W'(gi));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state plus next values of the registered strobe/ack/err outputs.
  // The ack is raised on every transition into HOLD, which places it one
  // cycle after the strobe for good writes and alongside err for bad ones.
  always_comb begin
    w_state_next   = r_state;
    w_reg_clk_next = '0;
    w_ack_a_next   = 1'b0;
    w_ack_b_next   = 1'b0;
    w_err_next     = 1'b0;
    w_latch        = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_gnt) begin
          w_latch      = 1'b1;
          w_state_next = SETUP;
        end
      end
      SETUP: begin
        if (w_addr_bad) begin
          w_err_next   = 1'b1;
          w_ack_a_next = ~r_gnt_b;
          w_ack_b_next = r_gnt_b;
          w_state_next = HOLD;
        end else begin
          w_reg_clk_next = w_dec;
          w_state_next   = STROBE;
        end
      end
      STROBE: begin
        w_ack_a_next = ~r_gnt_b;
        w_ack_b_next = r_gnt_b;
        w_state_next = HOLD;
      end
      HOLD: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Output flops and the grant-time capture of address and data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_reg_clk <= '0;
      r_ack_a   <= 1'b0;
      r_ack_b   <= 1'b0;
      r_err     <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_gnt_b   <= 1'b0;
    end else begin
      r_reg_clk <= w_reg_clk_next;
      r_ack_a   <= w_ack_a_next;
      r_ack_b   <= w_ack_b_next;
      r_err     <= w_err_next;
      if (w_latch) begin
        r_gnt_b <= w_gnt[1];
        r_addr  <= w_gnt[1] ? addr_b : addr_a;
        r_data  <= w_gnt[1] ? data_b : data_a;
      end
    end
  end

  assign reg_d   = r_data;
  assign reg_clk = r_reg_clk;
  assign ack_a   = r_ack_a;
  assign ack_b   = r_ack_b;
  assign err     = r_err;
  assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_octal_reg_write_sequencer.sv
// Self-checking bench: directed steps plus a randomized phase, checked
// against a transaction-level model of arbitration and the register bank.
module tb_octal_reg_write_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       req_a, req_b, ack_a, ack_b, busy, err;
  logic [1:0] addr_a, addr_b;
  logic [7:0] data_a, data_b, reg_d;
  logic [3:0] reg_clk;

  logic       t3_req_a, t3_req_b, t3_ack_a, t3_ack_b, t3_busy, t3_err;
  logic [1:0] t3_addr_a, t3_addr_b;
  logic [7:0] t3_data_a, t3_data_b, t3_reg_d;
  logic [2:0] t3_reg_clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] bank_obs [4];
  logic [7:0] bank_exp [4];
  bit         written  [4];
  bit         prio_b;
  bit         pend_a, pend_b, w;

  octal_reg_write_sequencer #(.NUM_REGS(4), .WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .addr_a(addr_a), .data_a(data_a), .ack_a(ack_a),
    .req_b(req_b), .addr_b(addr_b), .data_b(data_b), .ack_b(ack_b),
    .reg_d(reg_d), .reg_clk(reg_clk), .busy(busy), .err(err)
  );

  octal_reg_write_sequencer #(.NUM_REGS(3), .WIDTH(8)) dut3 (
    .clk(clk), .reset(reset),
    .req_a(t3_req_a), .addr_a(t3_addr_a), .data_a(t3_data_a), .ack_a(t3_ack_a),
    .req_b(t3_req_b), .addr_b(t3_addr_b), .data_b(t3_data_b), .ack_b(t3_ack_b),
    .reg_d(t3_reg_d), .reg_clk(t3_reg_clk), .busy(t3_busy), .err(t3_err)
  );

  // External 74x374 bank: each register captures the bus while its clock is high at an edge.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (reg_clk[i]) bank_obs[i] <= reg_d;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // No strobe cycle may ever clock more than one register.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      chk("onehot", 32'($countones(reg_clk) <= 1), 1);
      chk("onehot3", 32'($countones(t3_reg_clk) <= 1), 1);
    end
  end

  // Model of arbitration: a lone request wins, a tie goes to prio_b.
  function automatic bit pick_b(input bit ra, input bit rb);
    if (ra && rb) return prio_b;
    return rb;
  endfunction

  // Called at the negedge before the granting edge; returns at cycle +4.
  task automatic expect_write(input bit exp_b, input int addr, input logic [7:0] data,
                              input bit mangle);
    logic [3:0] strobe;
    strobe = 4'(1 << addr);
    @(negedge clk);
    chk("setup_busy", busy, 1);
    chk("setup_reg_d", reg_d, data);
    chk("setup_reg_clk", reg_clk, 0);
    @(negedge clk);
    chk("strobe_reg_clk", reg_clk, strobe);
    chk("strobe_reg_d", reg_d, data);
    chk("strobe_ack", {ack_b, ack_a}, 0);
    if (mangle) begin
      if (exp_b) data_b = 8'hFF; else data_a = 8'hFF;
    end
    @(negedge clk);
    chk("hold_ack", {ack_b, ack_a}, exp_b ? 2'b10 : 2'b01);
    chk("hold_reg_clk", reg_clk, 0);
    chk("hold_reg_d", reg_d, data);
    chk("hold_busy", busy, 1);
    if (exp_b) req_b = 1'b0; else req_a = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_ack", {ack_b, ack_a}, 0);
    chk("idle_reg_d", reg_d, data);
    chk("bank", bank_obs[addr], data);
    bank_exp[addr] = data;
    written[addr]  = 1'b1;
    prio_b = ~exp_b;
    $display("write %s reg%0d data=%02h", exp_b ? "B" : "A", addr, data);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    prio_b = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req_a = 0; req_b = 0; addr_a = 0; addr_b = 0; data_a = 0; data_b = 0;
    t3_req_a = 0; t3_req_b = 0; t3_addr_a = 0; t3_addr_b = 0; t3_data_a = 0; t3_data_b = 0;
    for (int i = 0; i < 4; i++) begin written[i] = 0; bank_exp[i] = 0; end
    prio_b = 0;
    repeat (2) @(negedge clk);

    // Reset wins over a simultaneous request; reset values.
    req_a = 1; addr_a = 2; data_a = 8'hA5;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_reg_d", reg_d, 0);
    chk("rst_reg_clk", reg_clk, 0);
    chk("rst_acks", {ack_b, ack_a}, 0);
    chk("rst_err", err, 0);
    chk("rst3_busy_err", {t3_busy, t3_err, t3_ack_a, t3_ack_b}, 0);
    reset = 0; prio_b = 0;
    expect_write(pick_b(1, 0), 2, 8'hA5, 0);

    // Simultaneous requests after reset: A first, B four cycles later.
    do_reset();
    req_a = 1; addr_a = 0; data_a = 8'h11;
    req_b = 1; addr_b = 3; data_b = 8'h33;
    w = pick_b(1, 1);
    expect_write(w, w ? 3 : 0, w ? 8'h33 : 8'h11, 0);
    w = pick_b(req_a, req_b);
    expect_write(w, w ? 3 : 0, w ? 8'h33 : 8'h11, 0);

    // Data changed mid-write is ignored.
    req_a = 1; addr_a = 1; data_a = 8'h5C;
    expect_write(pick_b(1, 0), 1, 8'h5C, 1);
    chk("mangle_reg_d_idle", reg_d, 8'h5C);

    // Both held requesting: strict alternation.
    req_a = 1; addr_a = 2'($urandom_range(0, 3)); data_a = 8'($urandom);
    req_b = 1; addr_b = 2'($urandom_range(0, 3)); data_b = 8'($urandom);
    for (int k = 0; k < 8; k++) begin
      bit prev;
      prev = prio_b;
      w = pick_b(1, 1);
      chk("alt_model", w, prev);
      expect_write(w, w ? int'(addr_b) : int'(addr_a), w ? data_b : data_a, 0);
      if (w) begin req_b = 1; addr_b = 2'($urandom_range(0, 3)); data_b = 8'($urandom); end
      else   begin req_a = 1; addr_a = 2'($urandom_range(0, 3)); data_a = 8'($urandom); end
    end
    req_a = 0; req_b = 0;

    // Randomized traffic against the model.
    pend_a = 0; pend_b = 0;
    for (int k = 0; k < 24; k++) begin
      if (!pend_a && $urandom_range(0, 1) == 1) begin
        pend_a = 1; req_a = 1; addr_a = 2'($urandom_range(0, 3)); data_a = 8'($urandom);
      end
      if (!pend_b && $urandom_range(0, 1) == 1) begin
        pend_b = 1; req_b = 1; addr_b = 2'($urandom_range(0, 3)); data_b = 8'($urandom);
      end
      if (!pend_a && !pend_b) begin
        @(negedge clk);
        chk("rand_idle_busy", busy, 0);
      end else begin
        w = pick_b(pend_a, pend_b);
        expect_write(w, w ? int'(addr_b) : int'(addr_a), w ? data_b : data_a, 0);
        if (w) pend_b = 0; else pend_a = 0;
      end
    end
    req_a = 0; req_b = 0;
    @(negedge clk);

    // Reset during STROBE truncates the write without ack.
    req_a = 1; addr_a = 1; data_a = 8'h3C;
    @(negedge clk);
    @(negedge clk);
    chk("abort_strobe", reg_clk, 4'b0010);
    reset = 1; req_a = 0;
    @(negedge clk);
    chk("abort_reg_clk", reg_clk, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ack", {ack_b, ack_a}, 0);
    reset = 0; prio_b = 0;
    @(negedge clk);
    chk("abort_noack", {ack_b, ack_a}, 0);
    req_a = 1; addr_a = 1; data_a = 8'h77;
    req_b = 1; addr_b = 2; data_b = 8'h88;
    w = pick_b(1, 1);
    expect_write(w, w ? 2 : 1, w ? 8'h88 : 8'h77, 0);
    w = pick_b(req_a, req_b);
    expect_write(w, w ? 2 : 1, w ? 8'h88 : 8'h77, 0);

    // Three-register bank: address 3 is rejected with err + ack, no strobe.
    t3_req_b = 1; t3_addr_b = 3; t3_data_b = 8'h9E;
    @(negedge clk);
    chk("oor_setup_busy", t3_busy, 1);
    chk("oor_setup_reg_d", t3_reg_d, 8'h9E);
    chk("oor_setup_err", t3_err, 0);
    chk("oor_setup_reg_clk", t3_reg_clk, 0);
    @(negedge clk);
    chk("oor_err", t3_err, 1);
    chk("oor_acks", {t3_ack_b, t3_ack_a}, 2'b10);
    chk("oor_reg_clk", t3_reg_clk, 0);
    t3_req_b = 0;
    @(negedge clk);
    chk("oor_idle", {t3_busy, t3_err, t3_ack_b, t3_ack_a}, 0);
    chk("oor_idle_reg_clk", t3_reg_clk, 0);
    $display("write B reg3 data=9e (rejected, 3-register bank)");

    // Highest valid address on the three-register bank still strobes.
    t3_req_a = 1; t3_addr_a = 2; t3_data_a = 8'h42;
    @(negedge clk);
    chk("r3_setup_err", t3_err, 0);
    @(negedge clk);
    chk("r3_strobe", t3_reg_clk, 3'b100);
    chk("r3_strobe_err", t3_err, 0);
    @(negedge clk);
    chk("r3_ack", {t3_ack_b, t3_ack_a}, 2'b01);
    t3_req_a = 0;
    @(negedge clk);
    chk("r3_idle_busy", t3_busy, 0);
    $display("write A reg2 data=42 (3-register bank)");

    // Final register bank contents versus the model.
    for (int i = 0; i < 4; i++) begin
      if (written[i]) chk($sformatf("final_bank%0d", i), bank_obs[i], bank_exp[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
